ahb_lite_regbank: RTL and testbench

// - Bus responder for the simplified single-master bus (write/trans/waddr/wdata -> readyout/rdata).
// - Backs a small bank of 8-bit read/write registers and inserts a programmable number of wait states.
// - Uses a full 4-phase handshake, so an initiator can hold a request until it is answered.
// - Sits beside, or in place of, the mode peripheral as a general scratch/config register target.

---
 rtl/ahb_lite_regbank_if.sv | 22 ++
 rtl/ahb_lite_regbank.sv | 152 +++++++++++++++
 tb/tb_ahb_lite_regbank.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_regbank_if.sv
// Request/response bundle between one initiator and the register bank.
// The initiator drives write/trans/waddr/wdata; the bank answers with
// readyout/rdata/err using a full 4-phase handshake on trans/readyout.
interface ahb_lite_regbank_if;
  logic       write;
  logic       trans;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       readyout;
  logic [7:0] rdata;
  logic       err;

  modport master (
    output write, trans, waddr, wdata,
    input  readyout, rdata, err
  );

  modport slave (
    input  write, trans, waddr, wdata,
    output readyout, rdata, err
  );
endinterface

// File: rtl/ahb_lite_regbank.sv
// Scratch/config register bank behind a 4-phase request/response handshake.
// Register 0 is a read-only ID; registers 1..NREGS-1 are 8-bit read/write.
// A request is captured once, answered after WAIT_STATES+1 edges, and the
// response is held until the initiator drops trans.
module ahb_lite_regbank #(
  parameter int         NREGS       = 8,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] ID          = 8'hA5
) (
  input logic               clock,
  input logic               rst,
  ahb_lite_regbank_if.slave bus
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hold_write_q, hold_write_d;
  logic [7:0] hold_addr_q, hold_addr_d;
  logic [7:0] hold_wdata_q, hold_wdata_d;
  logic       readyout_q, readyout_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  logic [7:0] regs_q [1:NREGS-1];

  logic          in_range;
  logic [AW-1:0] idx;
  logic [7:0]    rd_val;
  logic          wr_en;

  // Range check on the full 8-bit address before any narrowing, so high
  // addresses never alias onto a real register.
  assign in_range = (32'(hold_addr_q) < 32'(NREGS));
  assign idx      = hold_addr_q[AW-1:0];

  // Read mux: register 0 is the constant ID, the rest come from the bank.
  always_comb begin
    rd_val = ID;
    if (idx != '0) rd_val = regs_q[idx];
  end

  // Next-state and response logic for the request/response handshake.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    readyout_d   = readyout_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    wr_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.trans) begin
          hold_write_d = bus.write;
          hold_addr_d  = bus.waddr;
          hold_wdata_d = bus.wdata;
          // WAIT spends WAIT_STATES counted cycles plus one decode cycle, so
          // readyout lands WAIT_STATES+1 edges after this capture edge.
          cnt_d        = 4'(WAIT_STATES);
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        // trans is deliberately not looked at here: a captured request
        // always completes, even if the initiator lets go early.
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          readyout_d = 1'b1;
          if (!in_range) begin
            rdata_d = 8'h00;
            err_d   = 1'b1;
          end else if (hold_write_q) begin
            rdata_d = hold_wdata_q;
            err_d   = 1'b0;
            wr_en   = (idx != '0);
          end else begin
            rdata_d = rd_val;
            err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        // rdata keeps its last value after the handshake closes.
        if (!bus.trans) begin
          state_d    = S_IDLE;
          readyout_d = 1'b0;
          err_d      = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control, hold and response registers.
  always_ff @(posedge clock or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= 8'h00;
      hold_wdata_q <= 8'h00;
      readyout_q   <= 1'b0;
      rdata_q      <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      readyout_q   <= readyout_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Register bank storage; commits only on the response edge of a write.
  always_ff @(posedge clock or posedge rst) begin
    // NOTE: the bank is built from flops rather than a RAM macro, so it can
    // take the async reset and reads after reset are always defined.
    if (rst) begin
      for (int i = 1; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else if (wr_en) begin
      regs_q[idx] <= hold_wdata_q;
    end
  end

  assign bus.readyout = readyout_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ahb_lite_regbank.sv
// Bench for ahb_lite_regbank: five instances with different wait-state
// settings share one clock/reset. Instance 0 (WAIT_STATES=1) is shadowed
// by a cycle-level latency/register model; all instances get directed
// transactions with hand-computed expectations.
module tb_ahb_lite_regbank;

  localparam int NDUT = 5;
  localparam int WS0  = 1;

  function automatic int ws_of(input int i);
    case (i)
      0: return 1;
      1: return 0;
      2: return 3;
      3: return 4;
      default: return 15;
    endcase
  endfunction

  logic clock = 1'b0;
  logic rst   = 1'b1;

  logic            x_write = 1'b0;
  logic [7:0]      x_addr  = 8'h00;
  logic [7:0]      x_data  = 8'h00;
  logic [NDUT-1:0] x_trans = '0;

  wire [NDUT-1:0]      x_ready;
  wire [NDUT-1:0]      x_err;
  wire [NDUT-1:0][7:0] x_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    ahb_lite_regbank_if bus ();

    assign bus.write = x_write;
    assign bus.trans = x_trans[gi];
    assign bus.waddr = x_addr;
    assign bus.wdata = x_data;

    ahb_lite_regbank #(
      .NREGS      (8),
      .WAIT_STATES(ws_of(gi)),
      .ID         (8'hA5)
    ) dut (
      .clock(clock),
      .rst  (rst),
      .bus  (bus)
    );

    assign x_ready[gi] = bus.readyout;
    assign x_rdata[gi] = bus.rdata;
    assign x_err[gi]   = bus.err;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model of instance 0: an outstanding request becomes ready WS0+1 edges
  // after acceptance, resolves against an array of register values, and
  // stays ready until trans is seen low.
  // ---------------------------------------------------------------------
  logic       m_busy  = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_err   = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  int         m_due   = 0;
  logic       m_w;
  logic [7:0] m_a, m_d;
  logic [7:0] m_regs [8];

  initial forever begin
    @(posedge clock or posedge rst);
    if (rst) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_due   = 0;
      for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
    end else if (!m_busy) begin
      if (x_trans[0]) begin
        m_busy = 1'b1;
        m_w    = x_write;
        m_a    = x_addr;
        m_d    = x_data;
        m_due  = WS0 + 1;
      end
    end else if (!m_ready) begin
      m_due--;
      if (m_due == 0) begin
        m_ready = 1'b1;
        if (m_a >= 8) begin
          m_rdata = 8'h00;
          m_err   = 1'b1;
        end else if (m_w) begin
          m_rdata = m_d;
          m_err   = 1'b0;
          if (m_a != 0) m_regs[m_a[2:0]] = m_d;
        end else begin
          m_err   = 1'b0;
          m_rdata = (m_a == 0) ? 8'hA5 : m_regs[m_a[2:0]];
        end
      end
    end else if (!x_trans[0]) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_err   = 1'b0;
    end
  end

  // Per-cycle comparison of instance 0 against the model.
  initial forever begin
    @(negedge clock);
    #2;
    if (!rst) begin
      check("model_readyout", x_ready[0], m_ready);
      if (m_ready) begin
        check("model_rdata", x_rdata[0], m_rdata);
        check("model_err", x_err[0], m_err);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers; all are entered and left at a negedge.
  // ---------------------------------------------------------------------
  task automatic wait_ready(input int i, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (x_ready[i]) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout dut%0d: readyout never rose within 40 cycles", i);
    end
  endtask

  task automatic xact(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic e, output int lat);
    x_write    = w;
    x_addr     = a;
    x_data     = d;
    x_trans[i] = 1'b1;
    wait_ready(i, lat);
    rd         = x_rdata[i];
    e          = x_err[i];
    x_trans[i] = 1'b0;
    @(negedge clock);
    check($sformatf("ready_drop dut%0d", i), x_ready[i], 1'b0);
  endtask

  logic [7:0] rd;
  logic       e;
  int         lat;
  logic       seen;

  initial begin
    repeat (2) @(negedge clock);
    rst = 1'b0;
    @(negedge clock);

    // Reset state of every instance.
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst_ready dut%0d", i), x_ready[i], 1'b0);
      check($sformatf("rst_rdata dut%0d", i), x_rdata[i], 8'h00);
      check($sformatf("rst_err dut%0d", i), x_err[i], 1'b0);
    end

    // ID read with one wait state.
    xact(0, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("id_lat", lat, 2);
    check("id_rdata", rd, 8'hA5);
    check("id_err", e, 1'b0);

    // Write 3, read it back, other registers untouched.
    xact(0, 1'b1, 8'd3, 8'h5C, rd, e, lat);
    check("w3_echo", rd, 8'h5C);
    check("w3_err", e, 1'b0);
    xact(0, 1'b0, 8'd3, 8'h00, rd, e, lat);
    check("r3_rdata", rd, 8'h5C);
    for (int a = 1; a < 8; a++) begin
      if (a != 3) begin
        xact(0, 1'b0, 8'(a), 8'h00, rd, e, lat);
        check($sformatf("r%0d_zero", a), rd, 8'h00);
      end
    end

    // Register 0 is read-only.
    xact(0, 1'b1, 8'd0, 8'hFF, rd, e, lat);
    check("w0_echo", rd, 8'hFF);
    check("w0_err", e, 1'b0);
    xact(0, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("r0_after_w0", rd, 8'hA5);

    // Out-of-range accesses, including one whose low bits would alias reg 3.
    xact(0, 1'b0, 8'd8, 8'h00, rd, e, lat);
    check("r8_err", e, 1'b1);
    check("r8_rdata", rd, 8'h00);
    xact(0, 1'b1, 8'd200, 8'h11, rd, e, lat);
    check("w200_err", e, 1'b1);
    check("w200_rdata", rd, 8'h00);
    xact(0, 1'b1, 8'd11, 8'h11, rd, e, lat);
    check("w11_err", e, 1'b1);
    xact(0, 1'b0, 8'd3, 8'h00, rd, e, lat);
    check("r3_no_alias", rd, 8'h5C);
    xact(0, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("r0_no_alias", rd, 8'hA5);

    // Response held while trans stays high; address change mid-response ignored.
    xact(0, 1'b1, 8'd2, 8'h3C, rd, e, lat);
    x_write    = 1'b0;
    x_addr     = 8'd3;
    x_trans[0] = 1'b1;
    wait_ready(0, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check($sformatf("hold_ready c%0d", k), x_ready[0], 1'b1);
      check($sformatf("hold_rdata c%0d", k), x_rdata[0], 8'h5C);
      if (k == 1) x_addr = 8'd2;
    end
    x_trans[0] = 1'b0;
    @(negedge clock);
    check("hold_release", x_ready[0], 1'b0);
    xact(0, 1'b0, 8'd2, 8'h00, rd, e, lat);
    check("r2_after_hold", rd, 8'h3C);

    // Early trans drop during WAIT still completes the write (WAIT_STATES=3).
    x_write    = 1'b1;
    x_addr     = 8'd4;
    x_data     = 8'h99;
    x_trans[2] = 1'b1;
    @(negedge clock);
    x_trans[2] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      if (x_ready[2]) begin
        seen = 1'b1;
        break;
      end
    end
    check("early_drop_seen", seen, 1'b1);
    check("early_drop_echo", x_rdata[2], 8'h99);
    @(negedge clock);
    check("early_drop_release", x_ready[2], 1'b0);
    xact(2, 1'b0, 8'd4, 8'h00, rd, e, lat);
    check("early_drop_readback", rd, 8'h99);
    check("ws3_lat", lat, 4);

    // Reset in the middle of WAIT (WAIT_STATES=4) cancels the write.
    x_write    = 1'b1;
    x_addr     = 8'd5;
    x_data     = 8'h77;
    x_trans[3] = 1'b1;
    repeat (2) @(negedge clock);
    check("ws4_busy_ready", x_ready[3], 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", x_ready[3], 1'b0);
    x_trans[3] = 1'b0;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    xact(3, 1'b0, 8'd5, 8'h00, rd, e, lat);
    check("rst_mid_r5", rd, 8'h00);
    check("ws4_lat", lat, 5);
    xact(0, 1'b0, 8'd3, 8'h00, rd, e, lat);
    check("rst_clears_r3", rd, 8'h00);

    // Latency sweep.
    xact(1, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("ws0_lat", lat, 1);
    check("ws0_rdata", rd, 8'hA5);
    xact(2, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("ws3_id_lat", lat, 4);
    xact(4, 1'b0, 8'd0, 8'h00, rd, e, lat);
    check("ws15_lat", lat, 16);
    check("ws15_rdata", rd, 8'hA5);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
